// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select encodings and the branch-condition helper.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_MEM_ADR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JAL,
      S_JALR_ADR,
      S_JALR_PC,
      S_LUI,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b100,
      ALU_XOR = 3'b101
   } alu_op_t;

   typedef enum logic [1:0] {
      SRCA_PC     = 2'b00,
      SRCA_OLD_PC = 2'b01,
      SRCA_RS1    = 2'b10,
      SRCA_ZERO   = 2'b11
   } alu_srca_t;

   typedef enum logic [1:0] {
      SRCB_RS2    = 2'b00,
      SRCB_IMM    = 2'b01,
      SRCB_FOUR   = 2'b10,
      SRCB_UNUSED = 2'b11
   } alu_srcb_t;

   typedef enum logic [1:0] {
      RES_ALUOUT  = 2'b00,
      RES_MEMDATA = 2'b01,
      RES_ALU     = 2'b10
   } result_sel_t;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100
   } imm_sel_t;

   // Branch decision from the sub result flags; unsupported func3 never branches
   function automatic logic branch_taken(input logic [2:0] func3,
                                         input logic zero,
                                         input logic neg);
      case (func3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return neg;
         3'b101:  return !neg;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps func3/func7 to the 3-bit ALU operation; func7 only matters for R-type add/sub.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic       is_rtype,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output logic [2:0] alu_op
);

   logic unused_func7;

   assign unused_func7 = ^{func7[6], func7[4:0]};

   always_comb begin
      alu_op = ALU_ADD;
      case (func3)
         3'b000:  alu_op = (is_rtype && func7[5]) ? ALU_SUB : ALU_ADD;
         3'b111:  alu_op = ALU_AND;
         3'b110:  alu_op = ALU_OR;
         3'b010:  alu_op = ALU_SLT;
         3'b100:  alu_op = ALU_XOR;
         default: alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multi-cycle RV32I datapath.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes trap into an absorbing HALT state.
module multicycle_controller
   import riscv_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       zero,
   input  logic       neg,
   output logic       pc_we,
   output logic       adr_sel,
   output logic       ir_we,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] alu_srca,
   output logic [1:0] alu_srcb,
   output logic [2:0] alu_op,
   output logic [1:0] result_sel,
   output logic [2:0] imm_sel,
   output logic       instr_done,
   output logic       illegal
);

   state_t     state;
   state_t     state_next;
   logic       is_rtype;
   logic [2:0] dec_alu_op;

   assign is_rtype = (state == S_EXEC_R);

   alu_decoder u_alu_decoder (
      .is_rtype (is_rtype),
      .func3    (func3),
      .func7    (func7),
      .alu_op   (dec_alu_op)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

`ifndef ILLEGAL_TRAP_EN
   assign illegal = 1'b0;
`endif

   // Outputs stay quiet during reset so an abandoned instruction issues no write
   always_comb begin
      state_next = state;
      pc_we      = 1'b0;
      adr_sel    = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      alu_srca   = SRCA_PC;
      alu_srcb   = SRCB_RS2;
      alu_op     = ALU_ADD;
      result_sel = RES_ALUOUT;
      imm_sel    = IMM_I;
      instr_done = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal    = 1'b0;
`endif
      if (!rst) begin
         case (state)
            S_FETCH: begin
               ir_we      = 1'b1;
               pc_we      = 1'b1;
               alu_srcb   = SRCB_FOUR;
               result_sel = RES_ALU;
               state_next = S_DECODE;
            end
            S_DECODE: begin
               alu_srca = SRCA_OLD_PC;
               alu_srcb = SRCB_IMM;
               if (op == OP_BRANCH)   imm_sel = IMM_B;
               else if (op == OP_JAL) imm_sel = IMM_J;
               case (op)
                  OP_R:                state_next = S_EXEC_R;
                  OP_IALU:             state_next = S_EXEC_I;
                  OP_LOAD, OP_STORE:   state_next = S_MEM_ADR;
                  OP_BRANCH:           state_next = S_BRANCH;
                  OP_JAL:              state_next = S_JAL;
                  OP_JALR:             state_next = S_JALR_ADR;
                  OP_LUI:              state_next = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                  default:             state_next = S_HALT;
`else
                  default:             state_next = S_FETCH;
`endif
               endcase
            end
            S_EXEC_R: begin
               alu_srca   = SRCA_RS1;
               alu_op     = dec_alu_op;
               state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
               alu_srca   = SRCA_RS1;
               alu_srcb   = SRCB_IMM;
               alu_op     = dec_alu_op;
               state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
               reg_we     = 1'b1;
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
            S_MEM_ADR: begin
               alu_srca   = SRCA_RS1;
               alu_srcb   = SRCB_IMM;
               imm_sel    = (op == OP_STORE) ? IMM_S : IMM_I;
               state_next = (op == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               adr_sel    = 1'b1;
               state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
               result_sel = RES_MEMDATA;
               reg_we     = 1'b1;
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
            S_MEM_WR: begin
               adr_sel    = 1'b1;
               mem_we     = 1'b1;
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
            S_BRANCH: begin
               alu_srca   = SRCA_RS1;
               alu_op     = ALU_SUB;
               pc_we      = branch_taken(func3, zero, neg);
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
            S_JAL: begin
               alu_srca   = SRCA_OLD_PC;
               alu_srcb   = SRCB_FOUR;
               pc_we      = 1'b1;
               state_next = S_ALU_WB;
            end
            S_JALR_ADR: begin
               alu_srca   = SRCA_RS1;
               alu_srcb   = SRCB_IMM;
               state_next = S_JALR_PC;
            end
            S_JALR_PC: begin
               alu_srca   = SRCA_OLD_PC;
               alu_srcb   = SRCB_FOUR;
               pc_we      = 1'b1;
               state_next = S_ALU_WB;
            end
            S_LUI: begin
               alu_srca   = SRCA_ZERO;
               alu_srcb   = SRCB_IMM;
               imm_sel    = IMM_U;
               state_next = S_ALU_WB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: begin
               illegal    = 1'b1;
               state_next = S_HALT;
            end
`endif
            default: state_next = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-cycle
// instruction-class reference model.
module tb_multicycle_controller;

   localparam logic Y = 1'b1;
   localparam logic N = 1'b0;

   localparam logic [6:0] T_R      = 7'b0110011;
   localparam logic [6:0] T_IALU   = 7'b0010011;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_LUI    = 7'b0110111;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       zero;
   logic       neg;
   logic       pc_we, adr_sel, ir_we, mem_we, reg_we, instr_done, illegal;
   logic [1:0] alu_srca, alu_srcb, result_sel;
   logic [2:0] alu_op, imm_sel;
   logic [18:0] dut_vec;

   int total_checks = 0;
   int bad_checks   = 0;

   logic [6:0] legal_ops [8];

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .func3      (func3),
      .func7      (func7),
      .zero       (zero),
      .neg        (neg),
      .pc_we      (pc_we),
      .adr_sel    (adr_sel),
      .ir_we      (ir_we),
      .mem_we     (mem_we),
      .reg_we     (reg_we),
      .alu_srca   (alu_srca),
      .alu_srcb   (alu_srcb),
      .alu_op     (alu_op),
      .result_sel (result_sel),
      .imm_sel    (imm_sel),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   assign dut_vec = {pc_we, adr_sel, ir_we, mem_we, reg_we, alu_srca, alu_srcb,
                     alu_op, result_sel, imm_sel, instr_done, illegal};

   function automatic logic [18:0] pack_out(
      input logic pcw, input logic adr, input logic irw, input logic memw, input logic regw,
      input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ao,
      input logic [1:0] rs, input logic [2:0] im, input logic dn, input logic il);
      return {pcw, adr, irw, memw, regw, sa, sb, ao, rs, im, dn, il};
   endfunction

   function automatic logic [2:0] exp_alu(input logic rtype, input logic [2:0] f3,
                                          input logic [6:0] f7);
      case (f3)
         3'b000:  return (rtype && f7[5]) ? 3'b001 : 3'b000;
         3'b111:  return 3'b010;
         3'b110:  return 3'b011;
         3'b010:  return 3'b100;
         3'b100:  return 3'b101;
         default: return 3'b000;
      endcase
   endfunction

   function automatic int instr_len(input logic [6:0] o);
      case (o)
         T_BRANCH:                               return 3;
         T_R, T_IALU, T_STORE, T_JAL, T_LUI:     return 4;
         T_LOAD, T_JALR:                         return 5;
         default:                                return 2;
      endcase
   endfunction

   function automatic logic is_legal(input logic [6:0] o);
      return (instr_len(o) != 2);
   endfunction

   // Expected control word for cycle idx of an instruction, by instruction class
   function automatic logic [18:0] model_cycle(input logic [6:0] o, input logic [2:0] f3,
                                               input logic [6:0] f7, input logic z,
                                               input logic n, input int idx);
      logic [18:0] wb;
      logic [2:0]  dimm;
      logic        taken;
      wb    = pack_out(N, N, N, N, Y, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, Y, N);
      taken = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) ||
              (f3 == 3'b100 && n) || (f3 == 3'b101 && !n);
      dimm  = (o == T_BRANCH) ? 3'b010 : ((o == T_JAL) ? 3'b011 : 3'b000);
      if (idx == 0) return pack_out(Y, N, Y, N, N, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, N, N);
      if (idx == 1) return pack_out(N, N, N, N, N, 2'b01, 2'b01, 3'b000, 2'b00, dimm, N, N);
      case (o)
         T_R:
            if (idx == 2) return pack_out(N, N, N, N, N, 2'b10, 2'b00, exp_alu(Y, f3, f7), 2'b00, 3'b000, N, N);
            else return wb;
         T_IALU:
            if (idx == 2) return pack_out(N, N, N, N, N, 2'b10, 2'b01, exp_alu(N, f3, f7), 2'b00, 3'b000, N, N);
            else return wb;
         T_LOAD:
            if (idx == 2)      return pack_out(N, N, N, N, N, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, N, N);
            else if (idx == 3) return pack_out(N, Y, N, N, N, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, N, N);
            else               return pack_out(N, N, N, N, Y, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, Y, N);
         T_STORE:
            if (idx == 2) return pack_out(N, N, N, N, N, 2'b10, 2'b01, 3'b000, 2'b00, 3'b001, N, N);
            else return pack_out(N, Y, N, Y, N, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, Y, N);
         T_BRANCH:
            return pack_out(taken, N, N, N, N, 2'b10, 2'b00, 3'b001, 2'b00, 3'b000, Y, N);
         T_JAL:
            if (idx == 2) return pack_out(Y, N, N, N, N, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, N, N);
            else return wb;
         T_JALR:
            if (idx == 2)      return pack_out(N, N, N, N, N, 2'b10, 2'b01, 3'b000, 2'b00, 3'b000, N, N);
            else if (idx == 3) return pack_out(Y, N, N, N, N, 2'b01, 2'b10, 3'b000, 2'b00, 3'b000, N, N);
            else               return wb;
         T_LUI:
            if (idx == 2) return pack_out(N, N, N, N, N, 2'b11, 2'b01, 3'b000, 2'b00, 3'b100, N, N);
            else return wb;
         default: return 19'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [18:0] actual,
                              input logic [18:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
      end
   endtask

   // Entered just after a rising edge with the FSM in FETCH; stop_at < 0 runs it fully
   task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3,
                                input logic [6:0] f7, input logic z, input logic n,
                                input int stop_at);
      int len;
      len = instr_len(o);
      if (stop_at >= 0 && stop_at < len) len = stop_at;
      op = o; func3 = f3; func7 = f7; zero = z; neg = n;
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         checkOutput($sformatf("op%b_f3%b_c%0d", o, f3, i), dut_vec,
                     model_cycle(o, f3, f7, z, n, i));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      legal_ops = '{T_R, T_IALU, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI};
      rst = 1'b1; op = 7'd0; func3 = 3'd0; func7 = 7'd0; zero = 1'b0; neg = 1'b0;

      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         checkOutput($sformatf("reset_%0d", i), dut_vec, 19'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      applyStimulus(T_R,      3'b000, 7'b0000000, N, N, -1);
      applyStimulus(T_R,      3'b000, 7'b0100000, N, N, -1);
      applyStimulus(T_LOAD,   3'b010, 7'b0000000, N, N, -1);
      applyStimulus(T_STORE,  3'b010, 7'b0000000, N, N, -1);
      applyStimulus(T_BRANCH, 3'b000, 7'b0000000, Y, N, -1);
      applyStimulus(T_BRANCH, 3'b100, 7'b0000000, N, N, -1);
      applyStimulus(T_BRANCH, 3'b101, 7'b0000000, N, N, -1);
      applyStimulus(T_JALR,   3'b000, 7'b0000000, N, N, -1);
      applyStimulus(T_IALU,   3'b000, 7'b0100000, N, N, -1);

      // Reset landing on the write-back cycle must suppress the register write
      applyStimulus(T_R, 3'b111, 7'b0000000, N, N, 3);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("mid_instr_reset", dut_vec, 19'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(T_LUI, 3'b000, 7'b0000000, N, N, -1);

`ifndef ILLEGAL_TRAP_EN
      applyStimulus(7'b1111111, 3'b000, 7'b0000000, N, N, -1);
      applyStimulus(T_JAL, 3'b000, 7'b0000000, N, N, -1);
`endif

      for (int k = 0; k < 80; k++) begin
         logic [6:0] o;
`ifdef ILLEGAL_TRAP_EN
         o = legal_ops[$urandom_range(0, 7)];
`else
         if ($urandom_range(0, 8) == 8) begin
            o = 7'($urandom);
            while (is_legal(o)) o = 7'($urandom);
         end else begin
            o = legal_ops[$urandom_range(0, 7)];
         end
`endif
         applyStimulus(o, 3'($urandom), 7'($urandom), 1'($urandom), 1'($urandom), -1);
      end

`ifdef ILLEGAL_TRAP_EN
      applyStimulus(7'b1111111, 3'b000, 7'b0000000, N, N, -1);
      for (int i = 0; i < 10; i++) begin
         op = T_R;
         @(negedge clk);
         checkOutput($sformatf("halt_%0d", i), dut_vec,
                     pack_out(N, N, N, N, N, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, N, Y));
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(negedge clk);
      checkOutput("halt_reset", dut_vec, 19'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(T_LUI, 3'b000, 7'b0000000, N, N, -1);
`endif

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multi-cycle RV32I subset datapath. It is the counterpart of the datapath's status interface: it consumes op/func3/func7/zero/neg and drives every datapath enable and select.
- A Moore-style FSM sequences each instruction through 3–5 cycles.
- An ALU-decode sub-block maps func3/func7 to the 3-bit ALU operation.

Parameters:
- none (opcode/state encodings fixed in shared package)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- op  input  7  instruction[6:0] from instruction register
- func3  input  3  instruction[14:12]
- func7  input  7  instruction[31:25]
- zero  input  1  ALU result == 0
- neg  input  1  ALU result[31]
- pc_we  output  1  PC load enable
- adr_sel  output  1  memory address: 0 PC, 1 aluout register
- ir_we  output  1  instruction register + old_pc load enable
- mem_we  output  1  data memory write enable
- reg_we  output  1  register file write enable
- alu_srca  output  2  00 PC, 01 old_pc, 10 rs1, 11 zero
- alu_srcb  output  2  00 rs2, 01 imm, 10 const 4, 11 unused
- alu_op  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- result_sel  output  2  00 aluout reg, 01 mem data reg, 10 ALU result direct
- imm_sel  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- instr_done  output  1  one-cycle pulse in the final state of each instruction
- illegal  output  1  unknown opcode seen; only meaningful with ILLEGAL_TRAP_EN

Behaviour:
- Reset:
  - Synchronous, active-high; clk is the only clock.
  - On a rst cycle, state <= FETCH.
  - While rst is high, all write enables (pc_we, ir_we, mem_we, reg_we), instr_done and illegal are forced 0; selects are 0.
  - Reset asserted mid-instruction abandons it; no write is issued in that cycle.
- Opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011
  - BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111
- Every state not listed drives 0 on enables and 00 on selects.
- FETCH: adr_sel=0, ir_we=1, srca=00, srcb=10, alu_op=add, result_sel=10, pc_we=1. Next state DECODE.
- DECODE: srca=01, srcb=01, add (branch/JAL target into aluout). imm_sel from op: B for BRANCH, J for JAL, else I. Next state by op:
  - R -> EXEC_R
  - I-ALU -> EXEC_I
  - LOAD/STORE -> MEM_ADR
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR_ADR
  - LUI -> LUI
  - other -> FETCH
- EXEC_R: srca=10, srcb=00, alu_op=ALU-decode. Next ALU_WB.
- EXEC_I: srca=10, srcb=01, imm_sel=I, alu_op=ALU-decode. Next ALU_WB.
- ALU_WB: result_sel=00, reg_we=1, instr_done=1. Next FETCH.
- MEM_ADR: srca=10, srcb=01, add, imm_sel=I for LOAD, S for STORE. Next MEM_RD for LOAD, MEM_WR for STORE.
- MEM_RD: adr_sel=1. Next MEM_WB.
- MEM_WB: result_sel=01, reg_we=1, instr_done=1. Next FETCH.
- MEM_WR: adr_sel=1, mem_we=1, instr_done=1. Next FETCH.
- BRANCH: srca=10, srcb=00, sub, result_sel=00, instr_done=1.
  - pc_we = taken, where taken is: func3 000 zero; 001 !zero; 100 neg; 101 !neg; others 0.
  - Next FETCH.
- JAL: srca=01, srcb=10, add, result_sel=00, pc_we=1. Next ALU_WB (writes old_pc+4).
- JALR_ADR: srca=10, srcb=01, imm_sel=I, add. Next JALR_PC.
- JALR_PC: result_sel=00, pc_we=1, srca=01, srcb=10, add. Next ALU_WB.
- LUI: srca=11, srcb=01, imm_sel=U, add. Next ALU_WB.
- ALU-decode:
  - R-type: func3 000 gives add if func7[5]=0, sub if 1; 111 and; 110 or; 010 slt; 100 xor.
  - I-type: same mapping, with func7 ignored (000 is always add).
  - Unlisted func3 -> add.
- Latency in cycles: branch 3; R, I-ALU, store, JAL, LUI 4; load and JALR 5.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE moves to HALT. HALT is absorbing; all enables are 0 and illegal=1 until rst.
- Undefined: an unknown opcode returns DECODE -> FETCH as a NOP, with no instr_done; the illegal port is tied 0.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - state enum
  - alu_op, alu_srca/srcb, result_sel and imm_sel encodings
- Sub-module alu_decoder (combinational): inputs is_rtype, func3, func7; output alu_op.

Test Plan:
- Reset: rst high 2 cycles -> all enables 0. First post-reset cycle is FETCH with pc_we=1, ir_we=1, srcb=10.
- add (op 0110011, func3 000, func7 0000000) -> FETCH, DECODE, EXEC_R with alu_op 000, then ALU_WB with reg_we=1 and instr_done=1. Same with func7 0100000 -> alu_op 001.
- lw (0000011) -> 5 cycles; MEM_RD adr_sel=1; MEM_WB result_sel=01, reg_we=1. sw (0100011) -> MEM_WR mem_we=1, imm_sel=001, no reg_we.
- beq with zero=1 -> BRANCH pc_we=1. blt with neg=0 -> pc_we=0. bge with neg=0 -> pc_we=1. Each completes in 3 cycles.
- jalr -> JALR_ADR, JALR_PC (pc_we=1), ALU_WB (reg_we=1); 5 cycles total.
- op 1111111: without macro -> back to FETCH after DECODE, no writes. With ILLEGAL_TRAP_EN -> HALT, illegal=1 held 10 cycles, cleared by rst.
